sevenseg_scan_driver: RTL
=========================

# sevenseg_scan_driver

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It sits directly downstream of the clock's BCD digit counters (HH:MM) and consumes their 4-bit digit values. Each frame it snapshots the digits, then scans them one at a time. Between digit switches it inserts dead time to suppress ghosting, and it supports per-digit blinking for time-set mode.

## Interface
- CLK_HZ, 50_000_000, input clock frequency
- REFRESH_HZ, 1000, slot rate; SLOT_CYCLES = CLK_HZ/REFRESH_HZ (integer division)
- DEAD_CYCLES, 16, blanked cycles at the start of each slot; must be < SLOT_CYCLES (elaboration error otherwise)
- BLINK_HZ, 2, blink rate; BLINK_HALF = CLK_HZ/(2*BLINK_HZ) cycles per phase
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- digits_in  in  16  BCD digits; [3:0]=digit0 (min ones) … [15:12]=digit3 (hours tens)
- blink_mask  in  4  bit i set: digit i blinks
- colon_en  in  1  light the decimal point of digit 2 (colon position)
- seg_n  out  7  segments a..g on bits 0..6, active-low
- an_n  out  4  anode enables, active-low; an_n[i] selects digit i
- dp_n  out  1  decimal point, active-low
- frame_start  out  1  one-cycle pulse when a new snapshot is taken

## Operation
- **Counters:**
  - slot counter cnt: 0..SLOT_CYCLES-1
  - digit index idx: 0..3, scan order 0,1,2,3, wrapping to 0
  - blink counter with phase bit blink_off
- **Per-slot FSM:**
  - DEAD while cnt < DEAD_CYCLES; ON otherwise.
  - DEAD→ON when cnt reaches DEAD_CYCLES.
  - ON→DEAD on the slot wrap, which also advances idx.
- **Snapshot:**
  - digits_in, blink_mask and colon_en are captured into frame registers on the first clock after reset release, and at every slot wrap where idx==3.
  - frame_start pulses in that same cycle.
  - Input changes mid-frame are invisible until the next snapshot.
- **DEAD:** an_n=4'hF, seg_n=7'h7F, dp_n=1.
- **ON:**
  - an_n has only bit idx low.
  - seg_n = decode of snapshot digit idx.
  - dp_n=0 iff idx==2 and colon_en(snapshot).
- **Decode (seg_n):**
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
  - A–F (invalid BCD) = 7'h3F ("-")
- **Blink:**
  - blink_off toggles every BLINK_HALF cycles and resets to 0 (visible).
  - In ON with blink_off=1 and snapshot blink_mask[idx]=1, the slot is treated as DEAD: all outputs idle, timing unchanged.
  - dp_n follows the same blanking.

## Timing
- All outputs are registered.
- **Reset (asynchronous):**
  - Outputs: seg_n=7'h7F, an_n=4'hF, dp_n=1, frame_start=0.
  - Internal state: cnt=0, idx=0, blink counter=0, blink_off=0, snapshot=0.
- **Frame pattern after frame_start** (frame = 4*SLOT_CYCLES cycles):
  - DEAD_CYCLES cycles with an_n=4'hF, then SLOT_CYCLES-DEAD_CYCLES cycles with an_n=4'b1110.
  - Digits 1, 2 and 3 follow the same pattern in turn.
- seg_n, an_n and dp_n change in the same cycle; segments are never driven while an anode switches.
- The blink counter is free-running and independent of slot and frame boundaries. A phase flip mid-slot takes effect the next cycle.
- Reset asserted mid-slot: outputs go idle immediately. After release, scanning restarts at idx 0 with a fresh snapshot.

## Configuration
- **Macro:** LEADING_ZERO_BLANK_EN.
- **Defined:** during the digit-3 slot, if the snapshot digit 3 == 0, the slot is blanked as in DEAD for its whole duration. dp_n is unaffected, since the dp belongs to digit 2.
- **Undefined:** digit 3 shows "0" (seg_n=7'h40) like any other digit.

## Test plan
Bench parameters: CLK_HZ=1000, REFRESH_HZ=100 (SLOT_CYCLES=10), DEAD_CYCLES=2, BLINK_HZ=5 (BLINK_HALF=100).
- **Reset, then release with digits_in=16'h1234** -> frame_start for 1 cycle; an_n=F for 2 cycles; then an_n=4'b1110 with seg_n=7'h19 for 8 cycles; then digit1 7'h30, digit2 7'h24, digit3 7'h79; frame period 40 cycles.
- **Change digits_in to 16'h5678 at cycle 15 of a frame** -> current frame still shows 1234; the next frame, after frame_start, shows 8,7,6,5 (7'h00, 7'h78, 7'h02, 7'h12).
- **blink_mask=4'b0001** -> digit0 slot has an_n=F throughout while blink_off=1 (cycles 100–199 after reset); digits 1–3 are unaffected; digit0 is visible when blink_off=0.
- **digits_in=16'h12A4, colon_en=1** -> digit1 seg_n=7'h3F; dp_n=0 only in digit-2 ON cycles, 1 elsewhere, including digit-2 DEAD cycles.
- **digits_in=16'h0930** -> with LEADING_ZERO_BLANK_EN, the digit-3 slot has an_n=F for all 10 cycles; without it, an_n=4'b0111 with seg_n=7'h40 for 8 cycles.
- **Assert rst_n=0 at cycle 5 of the digit-2 ON phase** -> same cycle: an_n=F, seg_n=7'h7F, dp_n=1; after release, frame_start fires and the scan restarts at digit0.

Source files
------------

// File: rtl/sevenseg_scan_driver_if.sv
// Digit-value and display-pin bundle for the seven-segment scan driver.
// master: upstream digit source; slave: the scan driver itself.
interface sevenseg_scan_driver_if;
  logic [15:0] digits_in;
  logic [3:0]  blink_mask;
  logic        colon_en;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame_start;

  modport master (
    output digits_in, blink_mask, colon_en,
    input  seg_n, an_n, dp_n, frame_start
  );

  modport slave (
    input  digits_in, blink_mask, colon_en,
    output seg_n, an_n, dp_n, frame_start
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// 4-digit common-anode seven-segment scanner with dead time, per-digit blink and colon dp.
// Optional macro LEADING_ZERO_BLANK_EN: blank the hours-tens digit when it is zero.
module sevenseg_scan_driver #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int REFRESH_HZ  = 1000,
  parameter int DEAD_CYCLES = 16,
  parameter int BLINK_HZ    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sevenseg_scan_driver_if.slave bus
);
  localparam int SLOT_CYCLES = CLK_HZ / REFRESH_HZ;
  localparam int BLINK_HALF  = CLK_HZ / (2 * BLINK_HZ);
  localparam int CNT_W       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int BCNT_W      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [CNT_W-1:0]  SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DEAD_END   = CNT_W'(DEAD_CYCLES);
  localparam logic [BCNT_W-1:0] BLINK_LAST = BCNT_W'(BLINK_HALF - 1);

  generate
    if (DEAD_CYCLES < 0 || DEAD_CYCLES >= SLOT_CYCLES) begin : g_bad_dead_cycles
      $error("DEAD_CYCLES must be smaller than CLK_HZ/REFRESH_HZ");
    end
  endgenerate

  typedef enum logic {S_DEAD, S_ON} state_e;

  state_e              state_q, state_d;
  logic                started_q, started_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic                blink_off_q, blink_off_d;
  logic [15:0]         snap_digits_q, snap_digits_d;
  logic [3:0]          snap_mask_q, snap_mask_d;
  logic                snap_colon_q, snap_colon_d;
  logic [6:0]          seg_n_q, seg_n_d;
  logic [3:0]          an_n_q, an_n_d;
  logic                dp_n_q, dp_n_d;
  logic                frame_start_q, frame_start_d;
  logic                slot_wrap;
  logic                take_snap;
  logic                blank;
  logic [3:0]          cur_digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Slot/digit counters and frame snapshot; the first clock after reset starts a frame.
  always_comb begin
    started_d     = 1'b1;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    slot_wrap     = 1'b0;
    take_snap     = 1'b0;
    snap_digits_d = snap_digits_q;
    snap_mask_d   = snap_mask_q;
    snap_colon_d  = snap_colon_q;
    frame_start_d = 1'b0;
    if (!started_q) begin
      cnt_d     = '0;
      idx_d     = 2'd0;
      take_snap = 1'b1;
    end else if (cnt_q == SLOT_LAST) begin
      slot_wrap = 1'b1;
      cnt_d     = '0;
      idx_d     = idx_q + 2'd1;
      take_snap = (idx_q == 2'd3);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (take_snap) begin
      snap_digits_d = bus.digits_in;
      snap_mask_d   = bus.blink_mask;
      snap_colon_d  = bus.colon_en;
      frame_start_d = 1'b1;
    end
  end

  always_comb begin
    bcnt_d      = bcnt_q + BCNT_W'(1);
    blink_off_d = blink_off_q;
    if (bcnt_q == BLINK_LAST) begin
      bcnt_d      = '0;
      blink_off_d = ~blink_off_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DEAD:  if (cnt_d == DEAD_END) state_d = S_ON;
      S_ON:    if (slot_wrap && DEAD_CYCLES != 0) state_d = S_DEAD;
      default: state_d = S_DEAD;
    endcase
  end

  // Outputs are computed from next-state so pins change together with the scan state.
  always_comb begin
    cur_digit = snap_digits_d[{idx_d, 2'b00} +: 4];
    blank     = (state_d == S_DEAD) || (blink_off_d && snap_mask_d[idx_d]);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_d == 2'd3 && cur_digit == 4'd0) blank = 1'b1;
`endif
    an_n_d  = blank ? 4'hF : ~(4'b0001 << idx_d);
    seg_n_d = blank ? 7'h7F : seg_decode(cur_digit);
    dp_n_d  = blank | ~((idx_d == 2'd2) & snap_colon_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_DEAD;
      started_q     <= 1'b0;
      cnt_q         <= '0;
      idx_q         <= 2'd0;
      bcnt_q        <= '0;
      blink_off_q   <= 1'b0;
      snap_digits_q <= 16'h0000;
      snap_mask_q   <= 4'h0;
      snap_colon_q  <= 1'b0;
      seg_n_q       <= 7'h7F;
      an_n_q        <= 4'hF;
      dp_n_q        <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      started_q     <= started_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      bcnt_q        <= bcnt_d;
      blink_off_q   <= blink_off_d;
      snap_digits_q <= snap_digits_d;
      snap_mask_q   <= snap_mask_d;
      snap_colon_q  <= snap_colon_d;
      seg_n_q       <= seg_n_d;
      an_n_q        <= an_n_d;
      dp_n_q        <= dp_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.seg_n       = seg_n_q;
  assign bus.an_n        = an_n_q;
  assign bus.dp_n        = dp_n_q;
  assign bus.frame_start = frame_start_q;

endmodule
